hyper_txn_seq: RTL and testbench
================================

HYPER_TXN_SEQ -- requirements
Module: hyper_txn_seq

Interface
REQ-001 SHALL have parameter NB_CS, default 2: number of chip selects (1..4).
REQ-002 SHALL have parameter LEN_W, default 10: width of the burst length in 16-bit words.
REQ-003 SHALL have parameter TO_W, default 8: width of the read-timeout counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset: sys_clk_i  in  1  sole clock, all logic on rising edge; rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have the request ports:
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_write_i  in  1  1=write, 0=read
- req_cs_i  in  $clog2(NB_CS) (min 1)  chip-select index
- req_addr_i  in  32  halfword address
- req_len_i  in  LEN_W  burst words; 0 treated as 1
REQ-006 SHALL have the configuration ports:
- cfg_latency_i  in  4  initial latency in clocks; 0 treated as 1
- cfg_fixed_lat_i  in  1  1=always double latency
- cfg_timeout_i  in  TO_W  read idle limit; 0 disables the timeout
REQ-007 SHALL have the data ports:
- tx_data_i  in  16  write word
- tx_valid_i  in  1  write word valid
- tx_ready_o  out  1  write word consumed
- rx_data_o  out  16  read word
- rx_valid_o  out  1  read word valid, one-cycle pulse
REQ-008 SHALL have the PHY ports:
- phy_cs_n_o  out  NB_CS  active-low chip selects
- phy_ck_en_o  out  1  device clock enable
- phy_dq_o  out  16  one DDR word per cycle
- phy_dq_oe_o  out  1  DQ output enable
- phy_rwds_o  out  2  byte mask
- phy_rwds_oe_o  out  1  RWDS output enable
- phy_rwds_i  in  1  RWDS sample
- phy_dq_i  in  16  read word
- phy_rx_valid_i  in  1  read word strobe
REQ-009 SHALL have the status ports: busy_o  out  1  state is not IDLE; done_o  out  1  one-cycle completion pulse; err_o  out  1  one-cycle timeout pulse, coincident with done_o.

Function
REQ-010 SHALL implement the FSM IDLE -> CA -> LAT -> DATA -> END -> IDLE; the handshake fires only in IDLE (req_ready_o = IDLE and not rst_i).
REQ-011 SHALL latch write, cs, address, length and the effective latency on handshake; later changes to cfg_* SHALL NOT affect the running transaction.
REQ-012 SHALL, in CA, hold CA for exactly 3 cycles, driving the 48-bit CA word MSB-first as 16-bit slices with phy_dq_oe_o=1:
- bit47 = not write; bit46 = 0; bit45 = 1
- bits44:16 = addr[31:3]; bits15:3 = 0; bits2:0 = addr[2:0]
REQ-013 SHALL sample phy_rwds_i in the first CA cycle; double = cfg_fixed_lat_i OR sample.
REQ-014 SHALL hold LAT for L or 2L cycles (L = effective cfg_latency_i, 2L when double), with phy_dq_oe_o=0.
REQ-015 SHALL drive, in write DATA:
- tx_ready_o = tx_valid_i; phy_dq_o = tx_data_i
- phy_dq_oe_o = phy_rwds_oe_o = 1; phy_rwds_o = 2'b00
- phy_ck_en_o = tx_valid_i (stall pauses the device clock)
REQ-016 SHALL, in read DATA, keep phy_ck_en_o=1 and register each phy_rx_valid_i word to rx_data_o/rx_valid_o one cycle later.
REQ-017 SHALL count transferred words and leave DATA on the cycle the count reaches the length.
REQ-018 SHALL, in read DATA with cfg_timeout_i nonzero, count consecutive cycles without phy_rx_valid_i (reset by each word); on reaching cfg_timeout_i go to END and pulse err_o with done_o.
REQ-019 SHALL spend exactly 1 cycle in END with all phy_cs_n_o high and phy_ck_en_o=0, pulsing done_o in END.
REQ-020 SHALL, for CA..DATA, drive phy_cs_n_o low for the latched index only; phy_ck_en_o=1 in CA and LAT.
REQ-021 SHALL treat a phy_rx_valid_i word arriving in the END cycle or later as ignored.
REQ-022 SHALL NOT pulse rx_valid_o during write transactions.

Reset
REQ-023 SHALL, with rst_i high on a rising edge, enter IDLE and, regardless of state (including mid-burst), set:
- phy_cs_n_o all 1
- phy_ck_en_o, phy_dq_oe_o, phy_rwds_oe_o, tx_ready_o = 0
- rx_valid_o, done_o, err_o, busy_o = 0
- phy_dq_o, phy_rwds_o, rx_data_o = 0
- all counters = 0
REQ-024 SHALL produce no done_o after a transaction aborted by reset.

Verification
REQ-025 SHALL be covered by these directed scenarios:
- Read cs=1, addr=0x0000_1235, len=4, lat=6, fixed=0, rwds low -> CA words 0xA000,0x0246,0x0005; 6 LAT cycles; 4 rx_valid_o pulses; done_o once; phy_cs_n_o=2'b01 during transaction.
- Same read with phy_rwds_i high in CA -> LAT 12 cycles.
- Write len=3, tx_valid_i low 2 cycles after first word -> phy_ck_en_o low those 2 cycles; exactly 3 tx_ready_o; phy_rwds_o=0.
- Read len=2, timeout=5, one word then silence -> err_o and done_o pulse together 5 cycles after the last word; IDLE 1 cycle later.
- rst_i asserted during write DATA -> next cycle all cs_n high, busy_o=0, no done_o.
- req_len_i=0, cfg_latency_i=0 -> behaves as len=1, lat=1.

Source files
------------

// File: rtl/hyper_txn_seq.sv
// HyperBus-style transaction sequencer: command/address, initial latency, data burst, end.
// One 16-bit DDR word per sys_clk cycle on the PHY side; a read timeout guards against device stalls.
module hyper_txn_seq #(
  parameter int unsigned NB_CS = 2,
  parameter int unsigned LEN_W = 10,
  parameter int unsigned TO_W  = 8,
  localparam int unsigned CS_W = (NB_CS > 1) ? $clog2(NB_CS) : 1
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  // Request
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [CS_W-1:0]  req_cs_i,
  input  logic [31:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  // Configuration
  input  logic [3:0]       cfg_latency_i,
  input  logic             cfg_fixed_lat_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  // Data
  input  logic [15:0]      tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [15:0]      rx_data_o,
  output logic             rx_valid_o,
  // PHY
  output logic [NB_CS-1:0] phy_cs_n_o,
  output logic             phy_ck_en_o,
  output logic [15:0]      phy_dq_o,
  output logic             phy_dq_oe_o,
  output logic [1:0]       phy_rwds_o,
  output logic             phy_rwds_oe_o,
  input  logic             phy_rwds_i,
  input  logic [15:0]      phy_dq_i,
  input  logic             phy_rx_valid_i,
  // Status
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {StIdle, StCa, StLat, StData, StEnd} state_e;

  state_e           state_q;
  logic             write_q;
  logic [CS_W-1:0]  cs_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       lat_q;
  logic             fixed_q;
  logic [TO_W-1:0]  tmo_q;
  logic             double_q;
  logic [4:0]       phase_q;
  logic [4:0]       lat_cyc_q;
  logic [LEN_W-1:0] words_q;
  logic [TO_W-1:0]  idle_q;
  logic             err_q;
  logic [15:0]      rx_data_q;
  logic             rx_valid_q;

  logic [47:0]      ca_word;
  logic [LEN_W-1:0] words_inc;
  logic [TO_W-1:0]  idle_inc;
  logic             xfer;
  logic [NB_CS-1:0] cs_sel_n;

  assign ca_word   = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};
  assign words_inc = words_q + LEN_W'(1);
  assign idle_inc  = idle_q + TO_W'(1);
  assign xfer      = write_q ? tx_valid_i : phy_rx_valid_i;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      cs_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      lat_q      <= '0;
      fixed_q    <= 1'b0;
      tmo_q      <= '0;
      double_q   <= 1'b0;
      phase_q    <= '0;
      lat_cyc_q  <= '0;
      words_q    <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            write_q  <= req_write_i;
            cs_q     <= req_cs_i;
            addr_q   <= req_addr_i;
            len_q    <= (req_len_i == '0) ? LEN_W'(1) : req_len_i;
            lat_q    <= (cfg_latency_i == 4'd0) ? 4'd1 : cfg_latency_i;
            fixed_q  <= cfg_fixed_lat_i;
            tmo_q    <= cfg_timeout_i;
            double_q <= 1'b0;
            phase_q  <= '0;
            words_q  <= '0;
            idle_q   <= '0;
            err_q    <= 1'b0;
            state_q  <= StCa;
          end
        end
        StCa: begin
          // The device signals its latency requirement on RWDS during the first CA word.
          if (phase_q == 5'd0) begin
            double_q <= fixed_q | phy_rwds_i;
          end
          if (phase_q == 5'd2) begin
            phase_q   <= '0;
            lat_cyc_q <= double_q ? {lat_q, 1'b0} : {1'b0, lat_q};
            state_q   <= StLat;
          end else begin
            phase_q <= phase_q + 5'd1;
          end
        end
        StLat: begin
          if (phase_q == lat_cyc_q - 5'd1) begin
            phase_q <= '0;
            state_q <= StData;
          end else begin
            phase_q <= phase_q + 5'd1;
          end
        end
        StData: begin
          if (xfer) begin
            words_q <= words_inc;
            idle_q  <= '0;
            if (!write_q) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= phy_dq_i;
            end
            if (words_inc == len_q) begin
              state_q <= StEnd;
            end
          end else if (!write_q && tmo_q != '0) begin
            idle_q <= idle_inc;
            if (idle_inc == tmo_q) begin
              err_q   <= 1'b1;
              state_q <= StEnd;
            end
          end
        end
        StEnd: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NB_CS; i++) begin
      cs_sel_n[i] = (cs_q != CS_W'(i));
    end
  end

  always_comb begin
    phy_cs_n_o    = '1;
    phy_ck_en_o   = 1'b0;
    phy_dq_o      = '0;
    phy_dq_oe_o   = 1'b0;
    phy_rwds_o    = 2'b00;
    phy_rwds_oe_o = 1'b0;
    tx_ready_o    = 1'b0;
    unique case (state_q)
      StCa: begin
        phy_cs_n_o  = cs_sel_n;
        phy_ck_en_o = 1'b1;
        phy_dq_oe_o = 1'b1;
        unique case (phase_q)
          5'd0:    phy_dq_o = ca_word[47:32];
          5'd1:    phy_dq_o = ca_word[31:16];
          default: phy_dq_o = ca_word[15:0];
        endcase
      end
      StLat: begin
        phy_cs_n_o  = cs_sel_n;
        phy_ck_en_o = 1'b1;
      end
      StData: begin
        phy_cs_n_o = cs_sel_n;
        if (write_q) begin
          // A write-side stall freezes the device clock so no word is lost.
          tx_ready_o    = tx_valid_i;
          phy_dq_o      = tx_data_i;
          phy_dq_oe_o   = 1'b1;
          phy_rwds_oe_o = 1'b1;
          phy_ck_en_o   = tx_valid_i;
        end else begin
          phy_ck_en_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == StIdle) && !rst_i;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StEnd);
  assign err_o       = (state_q == StEnd) && err_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;

endmodule

// File: tb/tb_hyper_txn_seq.sv
// Self-checking bench for hyper_txn_seq: directed scenarios plus randomized transactions
// compared cycle by cycle against a timeline model built from the transaction rules.
module tb_hyper_txn_seq;

  localparam int unsigned NB_CS = 2;
  localparam int unsigned LEN_W = 10;
  localparam int unsigned TO_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid, req_ready, req_write;
  logic [0:0]       req_cs;
  logic [31:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [3:0]       cfg_latency;
  logic             cfg_fixed;
  logic [TO_W-1:0]  cfg_timeout;
  logic [15:0]      tx_data, rx_data, phy_dq, phy_dq_in;
  logic             tx_valid, tx_ready, rx_valid;
  logic [NB_CS-1:0] phy_cs_n;
  logic             phy_ck_en, phy_dq_oe, phy_rwds_oe, phy_rwds, phy_rx_valid;
  logic [1:0]       phy_rwds_mask;
  logic             busy, done, err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hyper_txn_seq #(.NB_CS(NB_CS), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .sys_clk_i      (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_cs_i       (req_cs),
    .req_addr_i     (req_addr),
    .req_len_i      (req_len),
    .cfg_latency_i  (cfg_latency),
    .cfg_fixed_lat_i(cfg_fixed),
    .cfg_timeout_i  (cfg_timeout),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .phy_cs_n_o     (phy_cs_n),
    .phy_ck_en_o    (phy_ck_en),
    .phy_dq_o       (phy_dq),
    .phy_dq_oe_o    (phy_dq_oe),
    .phy_rwds_o     (phy_rwds_mask),
    .phy_rwds_oe_o  (phy_rwds_oe),
    .phy_rwds_i     (phy_rwds),
    .phy_dq_i       (phy_dq_in),
    .phy_rx_valid_i (phy_rx_valid),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_cs       = 1'b0;
    req_addr     = '0;
    req_len      = '0;
    cfg_latency  = '0;
    cfg_fixed    = 1'b0;
    cfg_timeout  = '0;
    tx_data      = '0;
    tx_valid     = 1'b0;
    phy_rwds     = 1'b0;
    phy_dq_in    = '0;
    phy_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    idle_inputs();
    req_valid = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {phy_cs_n, busy, done, err, phy_ck_en, phy_dq_oe, phy_rwds_oe, tx_ready, rx_valid,
           req_ready};
    n_cmp++;
    if (got !== 11'b11_000000000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", got, 11'b11_000000000);
    end
    n_cmp++;
    if ({phy_dq, phy_rwds_mask, rx_data} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {phy_dq, phy_rwds_mask, rx_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got ready/busy %b want 10", {req_ready, busy});
    end
  endtask

  // One transaction. vpat bit i is the tx_valid (write) or word strobe (read) on the i-th
  // cycle after the latency window closes.
  task automatic run_txn(input string name, input bit wr, input bit [0:0] cs,
                         input logic [31:0] addr, input int len, input int lat, input bit fixed,
                         input bit rwds, input int tmo, input logic [255:0] vpat);
    int le, l, n, d, e, cnt, sil;
    bit to, in_ca, in_lat, in_data, exp_rxv;
    logic [47:0] ca;
    logic [1:0]  cs_mask;
    logic [15:0] dq_hist [0:319];
    bit          strb [0:319];
    bit          tv;
    logic [15:0] td, exp_dq;
    logic [10:0] exp_ctl, got_ctl;

    le = (len == 0) ? 1 : len;
    l  = (lat == 0) ? 1 : lat;
    n  = (fixed || rwds) ? 2 * l : l;
    d  = 3 + n;
    cnt = 0; sil = 0; e = -1; to = 1'b0;
    for (int i = 0; i < 256 && e < 0; i++) begin
      if (vpat[i]) begin
        cnt++;
        sil = 0;
        if (cnt == le) e = d + i + 1;
      end else if (!wr && tmo != 0) begin
        sil++;
        if (sil == tmo) begin
          e  = d + i + 1;
          to = 1'b1;
        end
      end
    end
    if (e < 0) begin
      $display("FAIL %s: stimulus pattern never completes the transaction", name);
      $fatal(1);
    end
    ca      = {~wr, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    cs_mask = ~(2'b01 << cs);

    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_write   = wr;
    req_cs      = cs;
    req_addr    = addr;
    req_len     = LEN_W'(len);
    cfg_latency = 4'(lat);
    cfg_fixed   = fixed;
    cfg_timeout = TO_W'(tmo);
    phy_rwds    = ~rwds;

    for (int c = 0; c <= e + 1; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (c == 0) begin
        // Scramble request and config after the handshake; the transaction must not notice.
        req_write   = 1'($urandom);
        req_addr    = $urandom;
        req_len     = LEN_W'($urandom);
        cfg_latency = 4'($urandom);
        cfg_fixed   = ~fixed;
        cfg_timeout = TO_W'($urandom);
      end
      phy_rwds   = (c == 0) ? rwds : ~rwds;
      dq_hist[c] = 16'($urandom);
      td         = 16'($urandom);
      tv         = (wr && c >= d) ? vpat[c-d] : 1'($urandom);
      strb[c]    = wr ? 1'($urandom) : (c >= d && vpat[c-d]);
      phy_dq_in    = dq_hist[c];
      phy_rx_valid = strb[c];
      tx_data      = td;
      tx_valid     = tv;
      @(negedge clk);

      in_ca   = (c < 3);
      in_lat  = (c >= 3 && c < d);
      in_data = (c >= d && c < e);
      exp_rxv = !wr && (c - 1 >= d) && (c - 1 < e) && strb[c-1];
      exp_ctl = {(c < e) ? cs_mask : 2'b11, c <= e, c == e, (c == e) && to,
                 in_ca || in_lat || (in_data && (!wr || tv)), in_ca || (in_data && wr),
                 in_data && wr, in_data && wr && tv, exp_rxv, c > e};
      got_ctl = {phy_cs_n, busy, done, err, phy_ck_en, phy_dq_oe, phy_rwds_oe, tx_ready,
                 rx_valid, req_ready};
      n_cmp++;
      if (got_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: got %b want %b (cs_n busy done err ck dqoe rwdsoe txr rxv rdy)",
                 name, c, got_ctl, exp_ctl);
      end
      if (in_ca || (in_data && wr)) begin
        case (c)
          0:       exp_dq = ca[47:32];
          1:       exp_dq = ca[31:16];
          2:       exp_dq = ca[15:0];
          default: exp_dq = td;
        endcase
        n_cmp++;
        if ({phy_dq, phy_rwds_mask} !== {exp_dq, 2'b00}) begin
          n_fail++;
          $display("FAIL %s dq cycle %0d: got %h/%b want %h/00", name, c, phy_dq, phy_rwds_mask,
                   exp_dq);
        end
      end
      if (exp_rxv) begin
        n_cmp++;
        if (rx_data !== dq_hist[c-1]) begin
          n_fail++;
          $display("FAIL %s rx_data cycle %0d: got %h want %h", name, c, rx_data, dq_hist[c-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_basic();
    run_txn("read_basic", 1'b0, 1'b1, 32'h0000_1235, 4, 6, 1'b0, 1'b0, 0, {256{1'b1}});
  endtask

  task automatic test_read_double();
    run_txn("read_double", 1'b0, 1'b1, 32'h0000_1235, 4, 6, 1'b0, 1'b1, 0, {256{1'b1}});
  endtask

  task automatic test_write_stall();
    run_txn("write_stall", 1'b1, 1'b0, 32'hDEAD_BEEF, 3, 4, 1'b0, 1'b0, 0, 256'b11001);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 1'b1, 32'h0000_1235, 2, 3, 1'b0, 1'b0, 5, 256'b1);
  endtask

  task automatic test_zero_len_lat();
    run_txn("zero_rd", 1'b0, 1'b0, $urandom, 0, 0, 1'b0, 1'b0, 0, {256{1'b1}});
    run_txn("zero_wr", 1'b1, 1'b1, $urandom, 0, 0, 1'b0, 1'b0, 0, {256{1'b1}});
  endtask

  task automatic test_reset_mid_write();
    int n_done;
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_cs      = 1'b0;
    req_addr    = $urandom;
    req_len     = LEN_W'(8);
    cfg_latency = 4'd2;
    tx_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tx_ready, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got txr/busy %b want 11", {tx_ready, busy});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({phy_cs_n, busy, done, err, phy_ck_en, phy_dq_oe, phy_rwds_oe, tx_ready, req_ready}
        !== 10'b11_0000_0001) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: got %b want 1100000001",
               {phy_cs_n, busy, done, err, phy_ck_en, phy_dq_oe, phy_rwds_oe, tx_ready, req_ready});
    end
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: got %0d done pulses want 0", n_done);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [255:0] vpat;
    bit wr;
    int tmo;
    for (int t = 0; t < 24; t++) begin
      wr  = 1'($urandom);
      tmo = (!wr && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      for (int i = 0; i < 256; i++) vpat[i] = ($urandom_range(0, 3) != 0);
      run_txn($sformatf("random%0d", t), wr, 1'($urandom), $urandom,
              int'($urandom_range(0, 9)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0), 1'($urandom), tmo, vpat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_read_double();
    test_write_stall();
    test_timeout();
    test_zero_len_lat();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
